chesssoc_usb_gpx_cond: RTL and testbench
========================================

// Module: chesssoc_usb_gpx_cond
// PURPOSE
//  Conditions the raw GPX pin from the MAX3421E USB controller before the GPX PIO samples it.
//  - Synchronises the pin into clk and applies a glitch filter.
//  - Drives the clean level to the PIO in_port.
//  - Adds an Avalon-MM slave with edge capture, IRQ mask and rising-edge counter.
//  - Sits directly upstream of the GPX PIO in the chesssoc system.
// PARAMETERS
//  SYNC_STAGES    2   synchroniser flop count (>=2)
//  FILTER_CYCLES  4   consecutive mismatching cycles required to change the filtered level (>=1)
//  CNT_WIDTH      16  rising-edge counter width (<=32)
// PORTS
//  clk        in   1   system clock; sole clock domain
//  reset_n    in   1   asynchronous active-low reset
//  gpx_pin    in   1   raw asynchronous GPX pin
//  gpx_out    out  1   filtered GPX level, wired to PIO in_port
//  chipselect in   1   Avalon slave select
//  address    in   2   register word address
//  write      in   1   write strobe, qualified by chipselect
//  writedata  in   32  write data
//  readdata   out  32  registered read data
//  irq        out  1   level interrupt, active high
// BEHAVIOUR
//  Reset (async, active-low): all flops clear.
//   - Synchroniser, filtered level, filter count, edge capture, mask and counter = 0.
//   - gpx_out = 0, readdata = 0, irq = 0.
//  Sync: gpx_pin passes through SYNC_STAGES flops. s = last stage output.
//  Filter:
//   - cnt resets to 0 on any cycle where s == level.
//   - If s != level and cnt == FILTER_CYCLES-1: level <= s, cnt <= 0.
//   - Otherwise, when s != level: cnt++.
//   - gpx_out = level.
//   - Latency: SYNC_STAGES+FILTER_CYCLES clk edges from the first edge that samples the new pin value.
//   - A pulse shorter than FILTER_CYCLES cycles after sync never reaches gpx_out.
//  Edges:
//   - rise/fall = one-cycle pulses when level goes 0->1 / 1->0.
//   - After reset with gpx_pin held high, one rise is produced after the filter latency.
//   - This rise is captured like any other edge.
//  Register map (32-bit words):
//   0 STATUS  RO  bit0 = level; bit1 = cap_rise; bit2 = cap_fall. Writes are ignored.
//   1 EDGECAP W1C bit0 = cap_rise; bit1 = cap_fall.
//      - Capture bits set on the matching edge.
//      - Writing 1 clears the bit.
//      - If a set and a clear hit the same bit in the same cycle, the set wins.
//   2 MASK    RW  bits[1:0] = {fall_en, rise_en}; other bits read 0.
//   3 COUNT   RW  rise counter, zero-extended on read.
//      - Increments on each rise and wraps from 2^CNT_WIDTH-1 to 0.
//      - Any write clears it, whatever the data.
//      - A write and a rise in the same cycle leave COUNT = 1.
//  Read:
//   - readdata <= mux(address) on every clk edge, independent of the read strobe.
//   - Read latency is 1 cycle. The value reflects register state before that edge.
//  Write: takes effect at the clk edge where chipselect & write are both high.
//  irq:
//   - irq = |(EDGECAP & MASK), decoded from registers only, so it carries no combinational path from the pin.
//   - irq rises 1 cycle after the edge pulse.
//  Reset mid-operation:
//   - A pending filter count is discarded.
//   - After release, the pin level is re-acquired from 0 with the full filter latency.
// TESTING
//  1. Reset with gpx_pin=0, then raise gpx_pin -> gpx_out=1 exactly 6 clks later; EDGECAP=0x1; COUNT=1; irq=0 (MASK=0).
//  2. Glitch: pin high for 3 clks, then low -> gpx_out stays 0; EDGECAP=0; COUNT=0.
//  3. Set MASK=0x2, then a full high->low cycle on the pin -> irq=1 on the cycle after the fall pulse.
//     Writing EDGECAP=0x2 drops irq the next cycle.
//  4. W1C write to bit0 in the same cycle as a rise pulse -> cap_rise stays 1.
//  5. Preload COUNT to 0xFFFF via 65535 rises (or force), apply one rise -> COUNT=0.
//     A COUNT write coincident with a rise -> COUNT=1.
//  6. Assert reset_n low mid-filter (cnt=2, pin high) -> gpx_out=0, readdata=0, irq=0 immediately.
//     After release with pin still high -> rise after 6 clks, EDGECAP=0x1.

Source files
------------

// File: rtl/chesssoc_usb_gpx_cond.sv
`default_nettype none
// ============================================================================
// Module   : chesssoc_usb_gpx_cond
// Purpose  : Conditions the raw MAX3421E GPX pin ahead of the GPX PIO.
//            The pin is synchronised into clk and glitch filtered, and the
//            clean level drives the PIO in_port. A small Avalon-MM slave adds
//            edge capture, an IRQ mask and a rising-edge counter.
// Revision : 1.0 - initial release
// ============================================================================
module chesssoc_usb_gpx_cond #(
  parameter int SYNC_STAGES   = 2,   // synchroniser depth, >= 2
  parameter int FILTER_CYCLES = 4,   // mismatching cycles needed to flip, >= 1
  parameter int CNT_WIDTH     = 16   // rising-edge counter width, <= 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        gpx_pin,
  output logic        gpx_out,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_CYCLES - 1);

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_EDGECAP = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  logic                   level_q, level_d;
  logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
  logic                   flip;

  logic                   rise_q, fall_q;
  logic [1:0]             cap_q, cap_d;
  logic [1:0]             mask_q, mask_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [31:0]            readdata_d;

  logic                   wr_en;
  logic                   wr_cap;
  logic                   wr_mask;
  logic                   wr_count;
  logic [1:0]             cap_clr;

  // Only the low two data bits are meaningful to any register.
  logic                   unused_wdata;
  assign unused_wdata = &{1'b0, writedata[31:2]};

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpx_pin};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Glitch filter: the level only follows the synchronised pin once it has
  // disagreed for FILTER_CYCLES consecutive cycles; any agreement restarts.
  always_comb begin
    level_d = level_q;
    fcnt_d  = fcnt_q;
    flip    = 1'b0;
    if (sync_s == level_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FCNT_MAX) begin
      level_d = sync_s;
      fcnt_d  = '0;
      flip    = 1'b1;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  // Bus write decode; chipselect qualifies the write strobe.
  always_comb begin
    wr_en    = chipselect & write;
    wr_cap   = wr_en && (address == ADDR_EDGECAP);
    wr_mask  = wr_en && (address == ADDR_MASK);
    wr_count = wr_en && (address == 2'd3);
    cap_clr  = wr_cap ? writedata[1:0] : 2'b00;
  end

  // Register next-state: a capture set beats a simultaneous W1C clear, and a
  // COUNT write coinciding with a rise leaves the counter at one.
  always_comb begin
    cap_d   = (cap_q & ~cap_clr) | {fall_q, rise_q};
    mask_d  = wr_mask ? writedata[1:0] : mask_q;
    count_d = wr_count ? CNT_WIDTH'(rise_q) : count_q + CNT_WIDTH'(rise_q);
  end

  // Read mux of the pre-edge register state, sampled every cycle.
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_STATUS:  readdata_d = {29'd0, cap_q[1], cap_q[0], level_q};
      ADDR_EDGECAP: readdata_d = {30'd0, cap_q};
      ADDR_MASK:    readdata_d = {30'd0, mask_q};
      default:      readdata_d = 32'(count_q);
    endcase
  end

  // Filter state, edge pulses and the register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q  <= 1'b0;
      fcnt_q   <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cap_q    <= 2'b00;
      mask_q   <= 2'b00;
      count_q  <= '0;
      readdata <= 32'd0;
    end else begin
      level_q  <= level_d;
      fcnt_q   <= fcnt_d;
      rise_q   <= flip & sync_s;
      fall_q   <= flip & ~sync_s;
      cap_q    <= cap_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      readdata <= readdata_d;
    end
  end

  // Outputs come straight from flops, so the pin has no combinational path.
  assign gpx_out = level_q;
  assign irq     = |(cap_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_chesssoc_usb_gpx_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_chesssoc_usb_gpx_cond
// Purpose  : Directed and random stimulus for chesssoc_usb_gpx_cond, checked
//            against a behavioural model (delay line + sliding window).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chesssoc_usb_gpx_cond;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int CW   = 4;   // narrow counter so the wrap is reachable quickly

  logic        clk;
  logic        reset_n;
  logic        gpx_pin;
  logic        gpx_out;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_pipe [SYNC];
  logic        m_win  [FILT];
  logic        m_level;
  logic        m_rise;
  logic        m_fall;
  logic [1:0]  m_cap;
  logic [1:0]  m_mask;
  int unsigned m_count;
  logic [31:0] m_rdata;

  chesssoc_usb_gpx_cond #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gpx_pin    (gpx_pin),
    .gpx_out    (gpx_out),
    .chipselect (chipselect),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
    for (int i = 0; i < FILT; i++) m_win[i] = 1'b0;
    m_level = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_cap   = 2'b00;
    m_mask  = 2'b00;
    m_count = 0;
    m_rdata = 32'd0;
  endtask

  // Advance the model over one clock edge, then compare all outputs.
  task automatic tick();
    logic       s;
    logic       all_diff;
    logic       we;
    logic [1:0] clr;
    logic       nrise;
    logic       nfall;
    we = chipselect & write;
    case (address)
      2'd0:    m_rdata = {29'd0, m_cap[1], m_cap[0], m_level};
      2'd1:    m_rdata = {30'd0, m_cap};
      2'd2:    m_rdata = {30'd0, m_mask};
      default: m_rdata = m_count;
    endcase
    clr   = (we && address == 2'd1) ? writedata[1:0] : 2'b00;
    m_cap = (m_cap & ~clr) | {m_fall, m_rise};
    if (we && address == 2'd2) m_mask = writedata[1:0];
    if (we && address == 2'd3) m_count = {31'd0, m_rise};
    else                       m_count = (m_count + {31'd0, m_rise}) % (1 << CW);
    // pin delay line
    s = m_pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = gpx_pin;
    // level flips when the last FILT synced samples all disagree with it
    for (int i = FILT - 1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = s;
    all_diff = 1'b1;
    for (int i = 0; i < FILT; i++) if (m_win[i] == m_level) all_diff = 1'b0;
    nrise = all_diff & ~m_level;
    nfall = all_diff & m_level;
    if (all_diff) m_level = ~m_level;
    m_rise = nrise;
    m_fall = nfall;
    @(posedge clk);
    #1;
    chk("gpx_out", {31'd0, gpx_out}, {31'd0, m_level});
    chk("irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    chk("readdata", readdata, m_rdata);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    tick();
    chk(tag, readdata, exp);
  endtask

  task automatic wait_level(input logic v, input int maxc, input string tag);
    int n;
    n = 0;
    while (gpx_out !== v && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, gpx_out}, {31'd0, v});
  endtask

  task automatic rise_once();
    gpx_pin = 1'b0;
    wait_level(1'b0, 20, "rise_wait_low");
    gpx_pin = 1'b1;
    wait_level(1'b1, 20, "rise_wait_high");
  endtask

  initial begin
    reset_n    = 1'b0;
    gpx_pin    = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    address    = 2'd0;
    writedata  = 32'd0;
    model_reset();
    #1;
    chk("rst_gpx_out", {31'd0, gpx_out}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1: clean rise appears exactly six edges after the pin changes
    repeat (3) tick();
    gpx_pin = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) chk("t1_not_yet", {31'd0, gpx_out}, 32'd0);
    end
    chk("t1_gpx_out", {31'd0, gpx_out}, 32'd1);
    repeat (2) tick();
    rd(2'd1, 32'h1, "t1_edgecap");
    rd(2'd3, 32'h1, "t1_count");
    chk("t1_irq", {31'd0, irq}, 32'd0);

    // 2: a three-cycle glitch is swallowed
    gpx_pin = 1'b0;
    wait_level(1'b0, 20, "t2_fall");
    repeat (4) tick();
    wr(2'd1, 32'h3);
    wr(2'd3, 32'h0);
    gpx_pin = 1'b1;
    repeat (3) tick();
    gpx_pin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_glitch", {31'd0, gpx_out}, 32'd0);
    end
    rd(2'd1, 32'h0, "t2_edgecap");
    rd(2'd3, 32'h0, "t2_count");

    // 3: masked fall raises irq one cycle after the pulse, W1C drops it
    wr(2'd2, 32'h2);
    gpx_pin = 1'b1;
    wait_level(1'b1, 20, "t3_rise");
    repeat (4) tick();
    wr(2'd1, 32'h3);
    gpx_pin = 1'b0;
    wait_level(1'b0, 20, "t3_fall");
    chk("t3_irq_pulse", {31'd0, irq}, 32'd0);
    tick();
    chk("t3_irq_set", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'h2);
    chk("t3_irq_clr", {31'd0, irq}, 32'd0);

    // 4: set beats a coincident W1C clear
    gpx_pin = 1'b1;
    wait_level(1'b1, 20, "t4_rise");
    wr(2'd1, 32'h1);
    rd(2'd1, 32'h1, "t4_set_wins");
    wr(2'd1, 32'h1);
    rd(2'd1, 32'h0, "t4_w1c");

    // 5: counter wrap and write-with-rise
    wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3, 32'h0, "t5_clear");
    repeat ((1 << CW) - 1) rise_once();
    tick();
    rd(2'd3, (1 << CW) - 1, "t5_full");
    rise_once();
    tick();
    rd(2'd3, 32'h0, "t5_wrap");
    gpx_pin = 1'b0;
    wait_level(1'b0, 20, "t5_low");
    gpx_pin = 1'b1;
    wait_level(1'b1, 20, "t5_high");
    wr(2'd3, 32'h5);
    rd(2'd3, 32'h1, "t5_wr_rise");

    // 6: reset in the middle of a filter run
    wr(2'd2, 32'h3);
    gpx_pin = 1'b0;
    wait_level(1'b0, 20, "t6_low");
    address = 2'd2;
    repeat (6) tick();
    gpx_pin = 1'b1;
    repeat (4) tick();
    chk("t6_pre_irq", {31'd0, irq}, 32'd1);
    chk("t6_pre_rdata", readdata, 32'h3);
    reset_n = 1'b0;
    #1;
    chk("t6_gpx_out", {31'd0, gpx_out}, 32'd0);
    chk("t6_readdata", readdata, 32'd0);
    chk("t6_irq", {31'd0, irq}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) chk("t6_not_yet", {31'd0, gpx_out}, 32'd0);
    end
    chk("t6_rise", {31'd0, gpx_out}, 32'd1);
    repeat (2) tick();
    rd(2'd1, 32'h1, "t6_edgecap");

    // random pin runs and bus traffic against the model
    for (int r = 0; r < 400; r++) begin
      int len;
      gpx_pin = 1'($urandom);
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        chipselect = ($urandom_range(0, 3) == 0);
        write      = 1'($urandom);
        address    = 2'($urandom);
        writedata  = $urandom;
        tick();
      end
    end
    chipselect = 1'b0;
    write      = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
